cpu_register_file: RTL and testbench

//  General-purpose register file of the 8-bit CPU datapath: six 8-bit registers,
//  one synchronous write port and one combinational read port to the load bus.

---
 rtl/cpu_register_file.sv | 60 ++++++
 tb/tb_cpu_register_file.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cpu_register_file.sv
// Six-entry 8-bit general-purpose register file: one synchronous write port,
// one combinational read port to the load bus, and three fixed ALU taps.
module cpu_register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int SEL_WIDTH  = 3,
    parameter int NUM_REGS   = 6,
    parameter int ALU_A_IDX  = 1,
    parameter int ALU_B_IDX  = 2,
    parameter int ALU_R_IDX  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  save,
    input  logic [SEL_WIDTH-1:0]  saveselector,
    input  logic [DATA_WIDTH-1:0] savebus,
    input  logic [SEL_WIDTH-1:0]  loadselector,
    output logic [DATA_WIDTH-1:0] loadbus,
    output logic [DATA_WIDTH-1:0] aluoperandA,
    output logic [DATA_WIDTH-1:0] aluoperandB,
    output logic [DATA_WIDTH-1:0] aluresult
);

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

    // Each register owns its own flop; selectors beyond NUM_REGS-1 match no
    // register, so writes to them are silently dropped.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_WIDTH-1:0] value_reg;
            logic                  hit;

            assign hit = save && (saveselector == SEL_WIDTH'(gi));

            always_ff @(posedge clock) begin
                if (reset) begin
                    value_reg <= '0;
                end else if (hit) begin
                    value_reg <= savebus;
                end
            end

            assign regs[gi] = value_reg;
        end
    endgenerate

    // Unimplemented selectors read back as zero rather than aliasing.
    always_comb begin
        loadbus = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (loadselector == SEL_WIDTH'(i)) begin
                loadbus = regs[i];
            end
        end
    end

    assign aluoperandA = regs[ALU_A_IDX];
    assign aluoperandB = regs[ALU_B_IDX];
    assign aluresult   = regs[ALU_R_IDX];

endmodule

// File: tb/tb_cpu_register_file.sv
// Table-driven bench for cpu_register_file; expected outputs travel through a
// scoreboard queue from the point of driving to the point of sampling.
module tb_cpu_register_file;

    logic       clock;
    logic       reset;
    logic       save;
    logic [2:0] saveselector;
    logic [7:0] savebus;
    logic [2:0] loadselector;
    logic [7:0] loadbus;
    logic [7:0] aluoperandA;
    logic [7:0] aluoperandB;
    logic [7:0] aluresult;

    cpu_register_file dut (
        .clock        (clock),
        .reset        (reset),
        .save         (save),
        .saveselector (saveselector),
        .savebus      (savebus),
        .loadselector (loadselector),
        .loadbus      (loadbus),
        .aluoperandA  (aluoperandA),
        .aluoperandB  (aluoperandB),
        .aluresult    (aluresult)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       sv;
        logic [2:0] ss;
        logic [7:0] sb;
        logic [2:0] ls;
        logic       edge_en;
        logic [7:0] el;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] er;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] el;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] er;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   txn        = 0;

    function automatic vec_t mk(input string name, input logic rst, input logic sv,
                                input logic [2:0] ss, input logic [7:0] sb,
                                input logic [2:0] ls, input logic edge_en,
                                input logic [7:0] el, input logic [7:0] ea,
                                input logic [7:0] eb, input logic [7:0] er);
        vec_t v;
        v.name = name; v.rst = rst; v.sv = sv; v.ss = ss; v.sb = sb; v.ls = ls;
        v.edge_en = edge_en; v.el = el; v.ea = ea; v.eb = eb; v.er = er;
        return v;
    endfunction

    task automatic cmp(input string name, input string field,
                       input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    task automatic check_front();
        exp_t e;
        if (sb_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard: empty queue at sample point");
            return;
        end
        e = sb_q.pop_front();
        txn++;
        $display("txn %0d %s: load=%h a=%h b=%h r=%h", txn, e.name,
                 loadbus, aluoperandA, aluoperandB, aluresult);
        cmp(e.name, "loadbus", loadbus, e.el);
        cmp(e.name, "aluoperandA", aluoperandA, e.ea);
        cmp(e.name, "aluoperandB", aluoperandB, e.eb);
        cmp(e.name, "aluresult", aluresult, e.er);
    endtask

    // Clock is driven one pulse at a time so combinational steps see no edge.
    task automatic apply(input vec_t v);
        exp_t e;
        reset = v.rst; save = v.sv; saveselector = v.ss;
        savebus = v.sb; loadselector = v.ls;
        e.name = v.name; e.el = v.el; e.ea = v.ea; e.eb = v.eb; e.er = v.er;
        sb_q.push_back(e);
        #2;
        if (v.edge_en) begin
            clock = 1'b1;
            #2;
            check_front();
            #3 clock = 1'b0;
            #3;
        end else begin
            check_front();
            #2;
        end
    endtask

    initial begin
        logic [7:0] after_sweep [6];
        clock = 1'b0; reset = 1'b0; save = 1'b0;
        saveselector = '0; savebus = '0; loadselector = '0;
        #5;

        vecs.push_back(mk("reset", 1, 0, 0, 8'h00, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00));
        for (int i = 1; i < 6; i++)
            vecs.push_back(mk("reset_read", 0, 0, 0, 8'h00, 3'(i), 0, 8'h00, 8'h00, 8'h00, 8'h00));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk("write", 0, 1, 3'(i), 8'(i + 1), 3'(i), 1, 8'(i + 1),
                              (i >= 1) ? 8'h02 : 8'h00, (i >= 2) ? 8'h03 : 8'h00,
                              (i >= 3) ? 8'h04 : 8'h00));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk("comb_read", 0, 0, 0, 8'h00, 3'(i), 0, 8'(i + 1), 8'h02, 8'h03, 8'h04));
        vecs.push_back(mk("overwrite_r", 0, 1, 3, 8'h55, 3, 1, 8'h55, 8'h02, 8'h03, 8'h55));
        vecs.push_back(mk("neighbour", 0, 0, 0, 8'h00, 4, 0, 8'h05, 8'h02, 8'h03, 8'h55));
        vecs.push_back(mk("save_low", 0, 0, 0, 8'hFF, 0, 1, 8'h01, 8'h02, 8'h03, 8'h55));
        vecs.push_back(mk("sel6_write", 0, 1, 6, 8'hFF, 6, 1, 8'h00, 8'h02, 8'h03, 8'h55));
        vecs.push_back(mk("sel7_write", 0, 1, 7, 8'hAA, 7, 1, 8'h00, 8'h02, 8'h03, 8'h55));
        after_sweep = '{8'h01, 8'h02, 8'h03, 8'h55, 8'h05, 8'h06};
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk("guard_read", 0, 0, 0, 8'h00, 3'(i), 0, after_sweep[i],
                              8'h02, 8'h03, 8'h55));

        foreach (vecs[k]) apply(vecs[k]);

        // No bypass: the pending write must not show before its edge.
        apply(mk("pre_edge", 0, 1, 2, 8'hA5, 2, 0, 8'h03, 8'h02, 8'h03, 8'h55));
        apply(mk("post_edge", 0, 1, 2, 8'hA5, 2, 1, 8'hA5, 8'h02, 8'hA5, 8'h55));
        apply(mk("full_range", 0, 1, 1, 8'hFF, 0, 1, 8'h01, 8'hFF, 8'hA5, 8'h55));

        // Reset wins over a simultaneous save, then every register reads zero.
        apply(mk("reset_and_save", 1, 1, 1, 8'h77, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00));
        for (int i = 0; i < 6; i++)
            apply(mk("post_reset_read", 0, 0, 0, 8'h00, 3'(i), 0, 8'h00, 8'h00, 8'h00, 8'h00));
        apply(mk("write_after_reset", 0, 1, 5, 8'h80, 5, 1, 8'h80, 8'h00, 8'h00, 8'h00));

        if (sb_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
